hdmi_pll_supervisor: RTL and testbench
======================================

# hdmi_pll_supervisor

Supervises the HDMI serial-clock rPLL from the 27 MHz reference domain. It pulses the PLL reset, waits for lock and checks that lock stays stable. It then measures the pixel-domain frequency through a heartbeat toggle and holds the video pipeline reset until the clock is proven good. It sits between the rPLL instance and the HDMI TMDS/timing logic, and re-runs the bring-up sequence whenever lock or frequency is lost.

## Interface
- RST_CYCLES, 16: cycles `pll_reset` is held high per attempt (≥1).
- LOCK_TIMEOUT, 270000: cycles allowed in WAIT_LOCK before retry (10 ms).
- STABLE_CYCLES, 27000: consecutive synchronized-lock-high cycles required (1 ms).
- GATE_CYCLES, 2700: measurement window length in `clkin` cycles (100 µs).
- EXP_EDGES, 464: expected `hb_toggle` transitions per window (74.25 MHz pixel clock, toggle every 16 pixel clocks).
- TOL, 8: allowed ± deviation from EXP_EDGES, inclusive.
- `clkin` in 1: 27 MHz reference clock. Only clock.
- `reset` in 1: synchronous, active-high.
- `pll_lock` in 1: rPLL LOCK. Asynchronous, synchronized internally.
- `hb_toggle` in 1: heartbeat from the pixel domain. Asynchronous, synchronized internally.
- `pll_reset` out 1: drives rPLL RESET.
- `vid_reset` out 1: active-high reset for the video pipeline.
- `ready` out 1: high only in RUN.
- `edge_count` out 12: edge count from the last completed window.
- `retries` out 8: number of PLL reset attempts after the first, saturating at 255.

## Operation
- Synchronizers: `pll_lock` and `hb_toggle` each pass through 2 flops. `hb_toggle` gets a third flop for edge detection. An edge is any change between flop 2 and flop 3.
- States: RESET_PLL, WAIT_LOCK, STABLE, MEASURE, RUN. One shared cycle counter, wide enough for LOCK_TIMEOUT, cleared on every state change.
- RESET_PLL: `pll_reset`=1. After RST_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK:
  - Synchronized lock high → STABLE.
  - Counter reaches LOCK_TIMEOUT−1 → RESET_PLL and retries+1.
- STABLE:
  - Synchronized lock low → WAIT_LOCK.
  - Lock high for STABLE_CYCLES consecutive cycles → MEASURE.
- MEASURE and RUN both run windows of GATE_CYCLES cycles. The edge counter clears at window start.
  - At window end, `edge_count` latches the count.
  - The window passes if |count − EXP_EDGES| ≤ TOL.
  - The edge counter saturates at 4095.
- MEASURE:
  - Pass → RUN.
  - Fail → RESET_PLL and retries+1.
- RUN:
  - One failed window sets a miss flag.
  - Two consecutive failed windows → RESET_PLL and retries+1.
  - A passing window clears the miss flag.
- Lock loss: synchronized lock low in MEASURE or RUN → RESET_PLL immediately and retries+1.
- Outputs:
  - `vid_reset`=1 in every state except RUN.
  - `vid_reset` and `ready` are registered and follow the state register.
- Simultaneous events: lock loss has priority over window end in the same cycle.
- `reset` mid-operation: returns to RESET_PLL next cycle and clears all counters, `retries`, `edge_count` and the miss flag.

## Timing
- Reset values:
  - State = RESET_PLL.
  - `pll_reset`=1, `vid_reset`=1, `ready`=0.
  - `edge_count`=0, `retries`=0.
- Lock sync latency: 2 cycles from `pll_lock` to the synchronized value. The state reacts on the following edge.
- Lock drop in RUN: `ready`=0 and `vid_reset`=1 no later than 4 cycles after `pll_lock` falls.
- `pll_reset` pulse width: exactly RST_CYCLES cycles per attempt.
- Minimum bring-up after lock rises (ideal clock), counted from the `pll_lock` edge:
  - 2 cycles sync.
  - STABLE_CYCLES.
  - GATE_CYCLES.
  - `ready` rises 1 cycle after the window end.
- `edge_count` updates on the cycle after the last window cycle.
- `hb_toggle` must change at most once per 2 `clkin` cycles; the nominal rate is about 1 per 5.8 cycles.

## Test plan
- Power-up: hold `reset` 5 cycles, release. `pll_lock` rises at cycle 100 and the toggle model runs at 74.25/16 MHz. Required:
  - `pll_reset` high for cycles 0–15.
  - `ready` rises at 100+2+27000+2700+1 (±2).
  - `edge_count` = 463..465.
  - `retries`=0.
- Lock never rises: `retries` increments every RST_CYCLES+LOCK_TIMEOUT cycles, with a fresh 16-cycle `pll_reset` pulse each time. `retries` saturates at 255 (shorten parameters in the bench).
- Lock glitch in STABLE: drop `pll_lock` for 3 cycles at STABLE cycle 1000. Required: return to WAIT_LOCK, the full STABLE_CYCLES count restarts, `retries` unchanged.
- Wrong frequency: toggle at 60% rate (~278 edges). Required: MEASURE fails, RESET_PLL, `retries`=1, `ready` never asserts.
- RUN fault handling:
  - One window at 440 edges: `ready` stays 1.
  - Two consecutive bad windows: `ready`=0 and `pll_reset`=1 the cycle after the second window ends.
  - Lock drop in RUN: `vid_reset`=1 within 4 cycles.
- `reset` asserted mid-RUN: next cycle state = RESET_PLL, `retries`=0, `edge_count`=0, `ready`=0.

Source files
------------

// File: rtl/hdmi_pll_supervisor_if.sv
// rtl/hdmi_pll_supervisor_if.sv - rPLL supervision signals between PLL/pixel domain and the supervisor
interface hdmi_pll_supervisor_if;
    logic        pll_lock;
    logic        hb_toggle;
    logic        pll_reset;
    logic        vid_reset;
    logic        ready;
    logic [11:0] edge_count;
    logic [7:0]  retries;

    modport master (
        input  pll_lock,
        input  hb_toggle,
        output pll_reset,
        output vid_reset,
        output ready,
        output edge_count,
        output retries
    );

    modport slave (
        output pll_lock,
        output hb_toggle,
        input  pll_reset,
        input  vid_reset,
        input  ready,
        input  edge_count,
        input  retries
    );
endinterface

// File: rtl/hdmi_pll_supervisor.sv
// rtl/hdmi_pll_supervisor.sv - rPLL bring-up, lock and pixel-frequency supervisor
module hdmi_pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 270000,
    parameter int STABLE_CYCLES = 27000,
    parameter int GATE_CYCLES   = 2700,
    parameter int EXP_EDGES     = 464,
    parameter int TOL           = 8
) (
    input  logic                   clkin,
    input  logic                   reset,
    hdmi_pll_supervisor_if.master  bus
);
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > GATE_CYCLES) ? STABLE_CYCLES : GATE_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int LO_INT  = (EXP_EDGES > TOL) ? (EXP_EDGES - TOL) : 0;

    localparam logic [12:0] PASS_LO = 13'(LO_INT);
    localparam logic [12:0] PASS_HI = 13'(EXP_EDGES + TOL);

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        MEASURE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [11:0]   ecnt;
    logic [11:0]   ecnt_next;
    logic          lock_s1;
    logic          lock_s2;
    logic          hb_s1;
    logic          hb_s2;
    logic          hb_s3;
    logic          hb_edge;
    logic          miss;
    logic          bump;
    logic          in_window;
    logic          win_end;
    logic          win_pass;
    logic          pll_reset_q;
    logic          vid_reset_q;
    logic          ready_q;
    logic [11:0]   edge_count_q;
    logic [7:0]    retries_q;

    assign hb_edge   = hb_s2 ^ hb_s3;
    assign ecnt_next = (hb_edge && (ecnt != 12'hFFF)) ? (ecnt + 12'd1) : ecnt;
    assign in_window = (state == MEASURE) || (state == RUN);
    assign win_end   = in_window && (cnt == CW'(GATE_CYCLES - 1));
    assign win_pass  = ({1'b0, ecnt_next} >= PASS_LO) && ({1'b0, ecnt_next} <= PASS_HI);

    // Lock loss is tested before window end so it always wins a same-cycle tie.
    always_comb begin
        state_n = state;
        bump    = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_s2) begin
                    state_n = STABLE;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    state_n = RESET_PLL;
                    bump    = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s2) begin
                    state_n = WAIT_LOCK;
                end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                if (!lock_s2) begin
                    state_n = RESET_PLL;
                    bump    = 1'b1;
                end else if (win_end) begin
                    if (win_pass) begin
                        state_n = RUN;
                    end else begin
                        state_n = RESET_PLL;
                        bump    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!lock_s2 || (win_end && !win_pass && miss)) begin
                    state_n = RESET_PLL;
                    bump    = 1'b1;
                end
            end
            default: begin
                state_n = RESET_PLL;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state        <= RESET_PLL;
            cnt          <= '0;
            ecnt         <= '0;
            lock_s1      <= 1'b0;
            lock_s2      <= 1'b0;
            hb_s1        <= 1'b0;
            hb_s2        <= 1'b0;
            hb_s3        <= 1'b0;
            miss         <= 1'b0;
            pll_reset_q  <= 1'b1;
            vid_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            edge_count_q <= '0;
            retries_q    <= '0;
        end else begin
            lock_s1 <= bus.pll_lock;
            lock_s2 <= lock_s1;
            hb_s1   <= bus.hb_toggle;
            hb_s2   <= hb_s1;
            hb_s3   <= hb_s2;
            state   <= state_n;

            if ((state_n != state) || win_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (in_window && (state_n == state) && !win_end) begin
                ecnt <= ecnt_next;
            end else begin
                ecnt <= '0;
            end

            if (win_end && lock_s2) begin
                edge_count_q <= ecnt_next;
            end

            if (state_n != RUN) begin
                miss <= 1'b0;
            end else if ((state == RUN) && win_end) begin
                miss <= !win_pass;
            end

            if (bump && (retries_q != 8'hFF)) begin
                retries_q <= retries_q + 8'd1;
            end

            // Outputs are registered from the next state so they change together with it.
            pll_reset_q <= (state_n == RESET_PLL);
            vid_reset_q <= (state_n != RUN);
            ready_q     <= (state_n == RUN);
        end
    end

    assign bus.pll_reset  = pll_reset_q;
    assign bus.vid_reset  = vid_reset_q;
    assign bus.ready      = ready_q;
    assign bus.edge_count = edge_count_q;
    assign bus.retries    = retries_q;
endmodule

// File: tb/tb_hdmi_pll_supervisor.sv
// tb/tb_hdmi_pll_supervisor.sv - directed self-checking bench for hdmi_pll_supervisor
module tb_hdmi_pll_supervisor;
    localparam int RST = 16;
    localparam int LT  = 120;
    localparam int S   = 300;
    localparam int G   = 2700;
    localparam int EXP = 464;
    localparam int TOL = 8;
    localparam int BRING = 3 + S + G;

    logic clkin;
    logic reset;
    int   n_pass;
    int   n_total;
    int   hb_num;
    int   phase;

    hdmi_pll_supervisor_if bus ();

    hdmi_pll_supervisor #(
        .RST_CYCLES   (RST),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(S),
        .GATE_CYCLES  (G),
        .EXP_EDGES    (EXP),
        .TOL          (TOL)
    ) dut (
        .clkin(clkin),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    // Fractional heartbeat: hb_num toggles per G reference cycles.
    initial begin
        bus.hb_toggle = 1'b0;
        phase = 0;
        forever begin
            @(negedge clkin);
            phase = phase + hb_num;
            if (phase >= G) begin
                phase = phase - G;
                bus.hb_toggle = ~bus.hb_toggle;
            end
        end
    end

    task automatic wait_ready(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clkin);
            if (bus.ready === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic restart_dut();
        reset = 1'b1;
        repeat (3) @(negedge clkin);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pll_lock = 1'b0;
        hb_num = EXP;
        repeat (5) @(negedge clkin);
        n_total++; if (bus.pll_reset !== 1'b1) $display("FAIL reset_pll_reset got %b exp 1", bus.pll_reset); else n_pass++;
        n_total++; if (bus.vid_reset !== 1'b1) $display("FAIL reset_vid_reset got %b exp 1", bus.vid_reset); else n_pass++;
        n_total++; if (bus.ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", bus.ready); else n_pass++;
        n_total++; if (bus.edge_count !== 12'd0) $display("FAIL reset_edge_count got %0d exp 0", bus.edge_count); else n_pass++;
        n_total++; if (bus.retries !== 8'd0) $display("FAIL reset_retries got %0d exp 0", bus.retries); else n_pass++;
    endtask

    task automatic test_power_up();
        int n;
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            n_total++;
            if (bus.pll_reset !== (k < RST)) $display("FAIL pu_pll_reset_c%0d got %b exp %b", k, bus.pll_reset, (k < RST));
            else n_pass++;
            @(negedge clkin);
        end
        repeat (80) @(negedge clkin);
        bus.pll_lock = 1'b1;
        wait_ready(BRING + 50, n);
        n_total++; if (n < BRING - 2 || n > BRING + 2) $display("FAIL pu_ready_latency got %0d exp %0d", n, BRING); else n_pass++;
        n_total++; if (bus.edge_count < 12'd463 || bus.edge_count > 12'd465) $display("FAIL pu_edge_count got %0d exp 463..465", bus.edge_count); else n_pass++;
        n_total++; if (bus.retries !== 8'd0) $display("FAIL pu_retries got %0d exp 0", bus.retries); else n_pass++;
        n_total++; if (bus.vid_reset !== 1'b0) $display("FAIL pu_vid_reset got %b exp 0", bus.vid_reset); else n_pass++;
    endtask

    // Entered aligned: the current negedge immediately follows a window end.
    task automatic test_run_faults();
        int n;
        hb_num = 440;
        repeat (G) @(negedge clkin);
        n_total++; if (bus.edge_count < 12'd436 || bus.edge_count > 12'd444) $display("FAIL run_bad_count got %0d exp 436..444", bus.edge_count); else n_pass++;
        n_total++; if (bus.ready !== 1'b1) $display("FAIL run_one_miss_ready got %b exp 1", bus.ready); else n_pass++;
        hb_num = EXP;
        repeat (G) @(negedge clkin);
        n_total++; if (bus.edge_count < 12'd460 || bus.edge_count > 12'd468) $display("FAIL run_recover_count got %0d exp 460..468", bus.edge_count); else n_pass++;
        n_total++; if (bus.ready !== 1'b1) $display("FAIL run_recover_ready got %b exp 1", bus.ready); else n_pass++;
        hb_num = 440;
        repeat (G) @(negedge clkin);
        n_total++; if (bus.ready !== 1'b1) $display("FAIL run_first_bad_ready got %b exp 1", bus.ready); else n_pass++;
        repeat (G) @(negedge clkin);
        n_total++; if (bus.ready !== 1'b0) $display("FAIL run_two_bad_ready got %b exp 0", bus.ready); else n_pass++;
        n_total++; if (bus.pll_reset !== 1'b1) $display("FAIL run_two_bad_pll_reset got %b exp 1", bus.pll_reset); else n_pass++;
        n_total++; if (bus.retries !== 8'd1) $display("FAIL run_two_bad_retries got %0d exp 1", bus.retries); else n_pass++;
        hb_num = EXP;
        wait_ready(BRING + RST + 100, n);
        n_total++; if (n < 0) $display("FAIL run_rebring_timeout got %0d exp ready", n); else n_pass++;
        n_total++; if (bus.edge_count < 12'd463 || bus.edge_count > 12'd465) $display("FAIL run_rebring_count got %0d exp 463..465", bus.edge_count); else n_pass++;
        bus.pll_lock = 1'b0;
        n = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clkin);
            if (bus.vid_reset === 1'b1 && bus.ready === 1'b0) begin
                n = i;
                break;
            end
        end
        n_total++; if (n < 1) $display("FAIL run_lock_drop_latency got %0d exp 1..4", n); else n_pass++;
        @(negedge clkin);
        n_total++; if (bus.retries !== 8'd2) $display("FAIL run_lock_drop_retries got %0d exp 2", bus.retries); else n_pass++;
        n_total++; if (bus.pll_reset !== 1'b1) $display("FAIL run_lock_drop_pll_reset got %b exp 1", bus.pll_reset); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        bus.pll_lock = 1'b1;
        wait_ready(BRING + LT + RST + 100, n);
        n_total++; if (n < 0) $display("FAIL mid_bring_timeout got %0d exp ready", n); else n_pass++;
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
        n_total++; if (bus.ready !== 1'b0) $display("FAIL mid_ready got %b exp 0", bus.ready); else n_pass++;
        n_total++; if (bus.pll_reset !== 1'b1) $display("FAIL mid_pll_reset got %b exp 1", bus.pll_reset); else n_pass++;
        n_total++; if (bus.vid_reset !== 1'b1) $display("FAIL mid_vid_reset got %b exp 1", bus.vid_reset); else n_pass++;
        n_total++; if (bus.retries !== 8'd0) $display("FAIL mid_retries got %0d exp 0", bus.retries); else n_pass++;
        n_total++; if (bus.edge_count !== 12'd0) $display("FAIL mid_edge_count got %0d exp 0", bus.edge_count); else n_pass++;
    endtask

    task automatic test_wrong_freq();
        int n;
        bit seen_ready;
        hb_num = 278;
        restart_dut();
        n = -1;
        seen_ready = 1'b0;
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clkin);
            if (bus.ready === 1'b1) seen_ready = 1'b1;
            if (bus.retries === 8'd1) begin
                n = i;
                break;
            end
        end
        n_total++; if (n < 0) $display("FAIL wf_retry_timeout got %0d exp retry", n); else n_pass++;
        n_total++; if (seen_ready !== 1'b0) $display("FAIL wf_ready_seen got %b exp 0", seen_ready); else n_pass++;
        n_total++; if (bus.edge_count < 12'd276 || bus.edge_count > 12'd280) $display("FAIL wf_edge_count got %0d exp 276..280", bus.edge_count); else n_pass++;
        n_total++; if (bus.pll_reset !== 1'b1) $display("FAIL wf_pll_reset got %b exp 1", bus.pll_reset); else n_pass++;
    endtask

    task automatic test_lock_glitch();
        int n;
        bus.pll_lock = 1'b0;
        hb_num = EXP;
        restart_dut();
        repeat (30) @(negedge clkin);
        bus.pll_lock = 1'b1;
        repeat (100) @(negedge clkin);
        bus.pll_lock = 1'b0;
        repeat (3) @(negedge clkin);
        bus.pll_lock = 1'b1;
        wait_ready(BRING + 50, n);
        n_total++; if (n < BRING - 2 || n > BRING + 2) $display("FAIL glitch_ready_latency got %0d exp %0d", n, BRING); else n_pass++;
        n_total++; if (bus.retries !== 8'd0) $display("FAIL glitch_retries got %0d exp 0", bus.retries); else n_pass++;
    endtask

    task automatic test_lock_never();
        int at;
        bus.pll_lock = 1'b0;
        hb_num = 0;
        reset = 1'b1;
        repeat (3) @(negedge clkin);
        reset = 1'b0;
        repeat (RST + LT - 1) @(negedge clkin);
        n_total++; if (bus.retries !== 8'd0) $display("FAIL ln_retries_before got %0d exp 0", bus.retries); else n_pass++;
        n_total++; if (bus.pll_reset !== 1'b0) $display("FAIL ln_pll_reset_before got %b exp 0", bus.pll_reset); else n_pass++;
        @(negedge clkin);
        n_total++; if (bus.retries !== 8'd1) $display("FAIL ln_retries_first got %0d exp 1", bus.retries); else n_pass++;
        n_total++; if (bus.pll_reset !== 1'b1) $display("FAIL ln_pulse_start got %b exp 1", bus.pll_reset); else n_pass++;
        repeat (RST - 1) @(negedge clkin);
        n_total++; if (bus.pll_reset !== 1'b1) $display("FAIL ln_pulse_last got %b exp 1", bus.pll_reset); else n_pass++;
        @(negedge clkin);
        n_total++; if (bus.pll_reset !== 1'b0) $display("FAIL ln_pulse_end got %b exp 0", bus.pll_reset); else n_pass++;
        at = -1;
        for (int i = RST + LT + RST + 1; i <= 36000; i++) begin
            @(negedge clkin);
            if (bus.retries === 8'd255) begin
                at = i;
                break;
            end
        end
        n_total++; if (at !== 255 * (RST + LT)) $display("FAIL ln_sat_time got %0d exp %0d", at, 255 * (RST + LT)); else n_pass++;
        repeat (3 * (RST + LT)) @(negedge clkin);
        n_total++; if (bus.retries !== 8'd255) $display("FAIL ln_saturated got %0d exp 255", bus.retries); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        hb_num  = EXP;
        reset   = 1'b1;
        bus.pll_lock = 1'b0;
        test_reset();
        test_power_up();
        test_run_faults();
        test_reset_mid_run();
        test_wrong_freq();
        test_lock_glitch();
        test_lock_never();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
